// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a registered one-hot grant, an encoded
// grant index and an optional hold timeout that rotates a long-running owner
// off the resource when other requesters are waiting.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       valid
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // With no timeout the hold counter simply saturates at its top value.
  localparam logic [7:0] HOLD_LIMIT = (MAX_HOLD == 0) ? 8'd255 : 8'(MAX_HOLD - 1);
  localparam bit TIMEOUT_EN = (MAX_HOLD != 0);

  state_t     state;
  state_t     state_next;
  logic [1:0] last;
  logic [1:0] last_next;
  logic [1:0] id_next;
  logic [3:0] gnt_next;
  logic [7:0] hold_cnt;
  logic [7:0] hold_next;
  logic [3:0] others;

  // Circular priority search: the first set bit after position 'from' wins.
  function automatic logic [1:0] search(input logic [3:0] vec, input logic [1:0] from);
    logic [1:0] idx;
    logic       found;
    search = from;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = from + 2'(k);
      if (!found && vec[idx]) begin
        search = idx;
        found  = 1'b1;
      end
    end
  endfunction

  // Next owner, rotation pointer and hold counter from the sampled requests.
  always_comb begin
    state_next = state;
    id_next    = gnt_id;
    last_next  = last;
    hold_next  = hold_cnt;
    others     = req & ~gnt;
    case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          state_next = GRANT;
          id_next    = search(req, last);
          last_next  = id_next;
          hold_next  = 8'd0;
        end
      end
      GRANT: begin
        if (!req[gnt_id]) begin
          if (req != 4'b0000) begin
            id_next   = search(req, last);
            last_next = id_next;
          end else begin
            state_next = IDLE;
            id_next    = 2'd0;
          end
          hold_next = 8'd0;
        end else if (TIMEOUT_EN && (hold_cnt == HOLD_LIMIT) && (others != 4'b0000)) begin
          id_next   = search(others, last);
          last_next = id_next;
          hold_next = 8'd0;
        end else if (hold_cnt != HOLD_LIMIT) begin
          hold_next = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        id_next    = 2'd0;
        hold_next  = 8'd0;
      end
    endcase
    gnt_next = (state_next == GRANT) ? (4'b0001 << id_next) : 4'b0000;
  end

  // State and output registers; last starts at 3 so requester 0 wins first.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      gnt_id   <= 2'd0;
      valid    <= 1'b0;
      last     <= 2'd3;
      hold_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      gnt      <= gnt_next;
      gnt_id   <= id_next;
      valid    <= (state_next == GRANT);
      last     <= last_next;
      hold_cnt <= hold_next;
    end
  end

  // Grant is one-hot or zero and agrees with the encoded index.
  assert property (@(posedge clock) disable iff (!n_reset) $onehot0(gnt));
  assert property (@(posedge clock) disable iff (!n_reset)
                   valid |-> (gnt == (4'b0001 << gnt_id)));
  // Every owner was requesting at the edge that granted it.
  assert property (@(posedge clock) disable iff (!n_reset)
                   valid |-> (($past(req) & gnt) != 4'b0000));

endmodule

// File: tb/tb_rr_arbiter4.sv
// Randomised and directed bench for rr_arbiter4 against a queue-free
// integer reference model of the round-robin rules.
module tb_rr_arbiter4;

  localparam int MAX_HOLD = 8;

  logic       clock = 1'b0;
  logic       n_reset = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       valid;

  int checks = 0;
  int failures = 0;

  int m_owner;
  int m_last;
  int m_hold;

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clock  (clock),
    .n_reset(n_reset),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .valid  (valid)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int ref_search(logic [3:0] r, int from);
    for (int k = 1; k <= 4; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  function void model_reset();
    m_owner = -1;
    m_last  = 3;
    m_hold  = 0;
  endfunction

  function void model_step(logic [3:0] r);
    logic [3:0] oth;
    if (m_owner < 0) begin
      if (r != 4'b0000) begin
        m_owner = ref_search(r, m_last);
        m_last  = m_owner;
        m_hold  = 0;
      end
    end else if (!r[m_owner]) begin
      if (r != 4'b0000) begin
        m_owner = ref_search(r, m_last);
        m_last  = m_owner;
      end else begin
        m_owner = -1;
      end
      m_hold = 0;
    end else begin
      oth = r & ~(4'b0001 << m_owner);
      if (MAX_HOLD != 0 && m_hold == MAX_HOLD - 1 && oth != 4'b0000) begin
        m_owner = ref_search(oth, m_last);
        m_last  = m_owner;
        m_hold  = 0;
      end else if (MAX_HOLD == 0) begin
        if (m_hold < 255) m_hold++;
      end else if (m_hold < MAX_HOLD - 1) begin
        m_hold++;
      end
    end
  endfunction

  function automatic logic [6:0] model_out();
    logic [3:0] g;
    if (m_owner < 0) return 7'b0000000;
    g = 4'b0001 << m_owner;
    return {g, 2'(m_owner), 1'b1};
  endfunction

  task cycle();
    @(posedge clock);
    model_step(req);
    #1;
  endtask

  task test_reset();
    n_reset = 1'b0;
    req = 4'b0000;
    model_reset();
    #3;
    checks++;
    if ({gnt, gnt_id, valid} !== 7'b0000000) begin
      failures++;
      $display("[TB] FAIL reset_async: got gnt=%b id=%0d valid=%b want all zero", gnt, gnt_id, valid);
    end
    @(posedge clock);
    @(posedge clock);
    #1;
    n_reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if ({gnt, gnt_id, valid} !== 7'b0000000) begin
        failures++;
        $display("[TB] FAIL reset_idle cycle %0d: got gnt=%b id=%0d valid=%b want all zero", i, gnt, gnt_id, valid);
      end
    end
  endtask

  task test_handoff();
    req = 4'b1010;
    cycle();
    checks++;
    if ({gnt, gnt_id, valid} !== {4'b0010, 2'd1, 1'b1}) begin
      failures++;
      $display("[TB] FAIL handoff_first: got gnt=%b id=%0d valid=%b want 0010/1/1", gnt, gnt_id, valid);
    end
    req = 4'b1000;
    cycle();
    checks++;
    if ({gnt, gnt_id, valid} !== {4'b1000, 2'd3, 1'b1}) begin
      failures++;
      $display("[TB] FAIL handoff_gapfree: got gnt=%b id=%0d valid=%b want 1000/3/1", gnt, gnt_id, valid);
    end
    req = 4'b0000;
    cycle();
    checks++;
    if ({gnt, gnt_id, valid} !== 7'b0000000) begin
      failures++;
      $display("[TB] FAIL handoff_idle: got gnt=%b id=%0d valid=%b want all zero", gnt, gnt_id, valid);
    end
  endtask

  task test_fair_rotation();
    req = 4'b1111;
    cycle();
    checks++;
    if (gnt_id !== 2'd0 || gnt !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL rotation_start: got gnt=%b id=%0d want 0001/0", gnt, gnt_id);
    end
    for (int g = 0; g < 4; g++) begin
      req = 4'b1111;
      cycle();
      checks++;
      if ({gnt, gnt_id, valid} !== model_out()) begin
        failures++;
        $display("[TB] FAIL rotation_hold %0d: got %b want %b", g, {gnt, gnt_id, valid}, model_out());
      end
      req = 4'b1111 & ~(4'b0001 << g);
      cycle();
      checks++;
      if (gnt_id !== 2'((g + 1) % 4) || !valid) begin
        failures++;
        $display("[TB] FAIL rotation_next %0d: got id=%0d valid=%b want id=%0d", g, gnt_id, valid, (g + 1) % 4);
      end
    end
    req = 4'b0000;
    cycle();
  endtask

  task test_hold_timeout();
    int  held;
    bit  done;
    req = 4'b0100;
    cycle();
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL timeout_grant: got gnt=%b want 0100", gnt);
    end
    req  = 4'b0101;
    held = 1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      checks++;
      if ({gnt, gnt_id, valid} !== model_out()) begin
        failures++;
        $display("[TB] FAIL timeout_model cycle %0d: got %b want %b", i, {gnt, gnt_id, valid}, model_out());
      end
      if (gnt == 4'b0100) held++;
      else done = 1'b1;
    end
    checks++;
    if (held != MAX_HOLD || gnt !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL timeout_length: got held=%0d then gnt=%b want held=%0d then 0001", held, gnt, MAX_HOLD);
    end
    req = 4'b0000;
    cycle();
  endtask

  task test_alone();
    req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2 || !valid) begin
        failures++;
        $display("[TB] FAIL alone cycle %0d: got gnt=%b id=%0d valid=%b want 0100/2/1", i, gnt, gnt_id, valid);
      end
    end
  endtask

  task test_reset_mid_grant();
    req = 4'b1000;
    cycle();
    checks++;
    if (gnt !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL midreset_setup: got gnt=%b want 1000", gnt);
    end
    #2;
    n_reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({gnt, gnt_id, valid} !== 7'b0000000) begin
      failures++;
      $display("[TB] FAIL midreset_clear: got gnt=%b id=%0d valid=%b want all zero", gnt, gnt_id, valid);
    end
    @(posedge clock);
    #1;
    n_reset = 1'b1;
    req = 4'b1001;
    cycle();
    checks++;
    if ({gnt, gnt_id, valid} !== {4'b0001, 2'd0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL midreset_first: got gnt=%b id=%0d valid=%b want 0001/0/1", gnt, gnt_id, valid);
    end
  endtask

  task test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 5) == 0) req = req ^ (4'b0001 << $urandom_range(0, 3));
      cycle();
      checks++;
      if ({gnt, gnt_id, valid} !== model_out()) begin
        failures++;
        $display("[TB] FAIL random cycle %0d req=%b: got %b want %b", i, req, {gnt, gnt_id, valid}, model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_handoff();
    test_fair_rotation();
    test_hold_timeout();
    test_alone();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
